// File: rtl/bytebeat_engine_if.sv
// PCM sample stream between the bytebeat generator and the output stage.
// The master drives the sample and its valid; the slave returns ready.
interface bytebeat_engine_if #(
    parameter int unsigned PCM_W = 8
);
    logic [PCM_W-1:0] pcm;
    logic             pcm_vld;
    logic             pcm_rdy;

    modport master (output pcm, output pcm_vld, input pcm_rdy);
    modport slave  (input pcm, input pcm_vld, output pcm_rdy);
endinterface

// File: rtl/bytebeat_engine.sv
// Multi-voice bytebeat generator: a prescaled time counter feeds one shared formula
// datapath evaluated once per voice; voice results are averaged into a PCM sample.
module bytebeat_engine #(
    parameter int unsigned PCM_W    = 8,
    parameter int unsigned T_W      = 16,
    parameter int unsigned DIV_W    = 12,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  restart,
    input  logic [DIV_W-1:0]      div,
    input  logic [3:0]            a,
    input  logic [3:0]            b,
    input  logic [3:0]            c,
    input  logic [3:0]            d,
    input  logic [2*CHANNELS-1:0] mode,
    output logic                  overrun,
    bytebeat_engine_if.master     pcm_if
);
    localparam int unsigned LOG2C = $clog2(CHANNELS);
    localparam int unsigned IDX_W = (LOG2C == 0) ? 1 : LOG2C;
    localparam int unsigned ACC_W = PCM_W + LOG2C;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_PRESENT} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [T_W-1:0]   t_lat_q, t_lat_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PCM_W-1:0] pcm_q, pcm_d;
    logic             overrun_q, overrun_d;

    logic             tick;
    logic             accept;
    logic [1:0]       sel;
    logic [T_W-1:0]   a_w, c_w, res;
    logic [PCM_W-1:0] voice;
    logic [ACC_W-1:0] acc_sum;

    // Shared formula datapath, evaluated for voice idx_q on latched time.
    always_comb begin
        a_w = T_W'(a);
        c_w = T_W'(c);
        sel = mode[2*int'(idx_q) +: 2];
        res = '0;
        case (sel)
            2'd0: res = ((t_lat_q * a_w) & (t_lat_q >> b)) | ((t_lat_q * c_w) & (t_lat_q >> d));
            2'd1: res = (t_lat_q * a_w) ^ (t_lat_q >> b) ^ ((t_lat_q * c_w) >> d);
            2'd2: res = (t_lat_q * (a_w + ((t_lat_q >> b) & c_w))) >> d;
            default: res = ((t_lat_q * a_w) + ((t_lat_q >> b) & (t_lat_q >> c))) >> d;
        endcase
        voice   = res[PCM_W-1:0];
        acc_sum = acc_q + ACC_W'(voice);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        t_lat_d   = t_lat_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        pcm_d     = pcm_q;

        tick   = en && (cnt_q >= div);
        accept = tick && ((state_q == S_IDLE) || ((state_q == S_PRESENT) && pcm_if.pcm_rdy));

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
        if (tick) begin
            t_d = t_q + T_W'(1);
        end

        case (state_q)
            S_COMPUTE: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    pcm_d   = PCM_W'(acc_sum >> LOG2C);
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (pcm_if.pcm_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A tick accepted in IDLE or in a transfer cycle starts the next sample.
        if (accept) begin
            t_lat_d = t_q;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_COMPUTE;
        end

        overrun_d = tick && !accept;

        if (restart) begin
            cnt_d     = '0;
            t_d       = '0;
            state_d   = S_IDLE;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            t_q       <= '0;
            t_lat_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            pcm_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            t_lat_q   <= t_lat_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            pcm_q     <= pcm_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm_if.pcm     = pcm_q;
    assign pcm_if.pcm_vld = (state_q == S_PRESENT);
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_bytebeat_engine.sv
// Directed bench for bytebeat_engine: default-parameter instance plus a T_W=8,
// single-voice instance used to observe time-counter wrap.
module tb_bytebeat_engine;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        restart;
    logic [11:0] div;
    logic [3:0]  a, b, c, d;
    logic [3:0]  mode;
    logic        overrun;
    logic        overrun8;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ovr_cnt = 0;

    bytebeat_engine_if #(.PCM_W(8)) bus ();
    bytebeat_engine_if #(.PCM_W(8)) bus8 ();

    bytebeat_engine #(.PCM_W(8), .T_W(16), .DIV_W(12), .CHANNELS(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .div(div),
        .a(a), .b(b), .c(c), .d(d), .mode(mode), .overrun(overrun), .pcm_if(bus.master)
    );

    bytebeat_engine #(.PCM_W(8), .T_W(8), .DIV_W(12), .CHANNELS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .div(div),
        .a(a), .b(b), .c(c), .d(d), .mode(mode[1:0]), .overrun(overrun8), .pcm_if(bus8.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;
    always @(posedge clk) if (overrun === 1'b1) ovr_cnt++;

    task automatic next_sample(input bit which, output logic [7:0] v, output int at);
        bit got;
        got = 1'b0;
        v   = '0;
        at  = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (!which && bus.pcm_vld === 1'b1 && bus.pcm_rdy === 1'b1) begin
                got = 1'b1; v = bus.pcm; at = cyc;
            end else if (which && bus8.pcm_vld === 1'b1 && bus8.pcm_rdy === 1'b1) begin
                got = 1'b1; v = bus8.pcm; at = cyc;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL sample_timeout: got no sample within 400 cycles, required one");
        end
    endtask

    task automatic restart_pulse(output int r);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r = cyc;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        int at, base;
        rst_n = 1'b0; en = 1'b1; restart = 1'b0; div = 12'd3;
        a = 4'd1; b = 4'd0; c = 4'd0; d = 4'd0; mode = 4'b0000;
        bus.pcm_rdy = 1'b1; bus8.pcm_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.pcm !== 8'd0) begin errors++; $display("FAIL reset_pcm: got %0d required 0", bus.pcm); end
        checks++; if (bus.pcm_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", bus.pcm_vld); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        rst_n = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            next_sample(1'b0, v, at);
            checks++; if (v !== 8'(k)) begin errors++; $display("FAIL first_sample_val%0d: got %0d required %0d", k, v, k); end
            checks++; if (at - base != 6 + 4*k) begin errors++; $display("FAIL first_sample_time%0d: got %0d required %0d", k, at - base, 6 + 4*k); end
        end
    endtask

    task automatic test_mixing;
        logic [7:0] v;
        int at, r;
        logic [7:0] s [0:5];
        mode = 4'b0100;
        restart_pulse(r);
        for (int j = 0; j < 6; j++) begin next_sample(1'b0, v, at); s[j] = v; end
        checks++; if (s[3] !== 8'd1) begin errors++; $display("FAIL mix_m0m1_t3: got %0d required 1", s[3]); end
        checks++; if (s[5] !== 8'd2) begin errors++; $display("FAIL mix_m0m1_t5: got %0d required 2", s[5]); end
        mode = 4'b0000;
        restart_pulse(r);
        for (int j = 0; j < 6; j++) begin next_sample(1'b0, v, at); s[j] = v; end
        checks++; if (s[5] !== 8'd5) begin errors++; $display("FAIL mix_m0m0_t5: got %0d required 5", s[5]); end
    endtask

    task automatic test_formulas;
        logic [7:0] v;
        int at, r;
        logic [3:0] va [0:4] = '{4'd3, 4'd3, 4'd2, 4'd9, 4'd2};
        logic [3:0] vb [0:4] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
        logic [3:0] vc [0:4] = '{4'd5, 4'd7, 4'd3, 4'd1, 4'd3};
        logic [3:0] vd [0:4] = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd1};
        logic [3:0] vm [0:4] = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b1110};
        logic [7:0] ve [0:4] = '{8'd3, 8'd28, 8'd10, 8'd45, 8'd7};
        for (int n = 0; n < 5; n++) begin
            a = va[n]; b = vb[n]; c = vc[n]; d = vd[n]; mode = vm[n];
            restart_pulse(r);
            for (int j = 0; j < 6; j++) next_sample(1'b0, v, at);
            checks++; if (v !== ve[n]) begin errors++; $display("FAIL formula%0d_t5: got %0d required %0d", n, v, ve[n]); end
        end
        a = 4'd1; b = 4'd0; c = 4'd0; d = 4'd0; mode = 4'b0000;
    endtask

    task automatic test_backpressure;
        logic [7:0] v;
        int at, r, o0;
        bit held;
        div = 12'd3;
        restart_pulse(r);
        bus.pcm_rdy = 1'b0;
        o0 = ovr_cnt;
        held = 1'b1;
        while (cyc < r + 10) begin
            @(negedge clk);
            if (cyc >= r + 6 && (bus.pcm_vld !== 1'b1 || bus.pcm !== 8'd0)) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL bp_hold: got vld=%b pcm=%0d required vld=1 pcm=0 held", bus.pcm_vld, bus.pcm); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL bp_overrun: got %0d pulses required 1", ovr_cnt - o0); end
        bus.pcm_rdy = 1'b1;
        next_sample(1'b0, v, at);
        checks++; if (v !== 8'd2) begin errors++; $display("FAIL bp_next_val: got %0d required 2", v); end
        checks++; if (at - r != 14) begin errors++; $display("FAIL bp_next_time: got %0d required 14", at - r); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL bp_overrun_after: got %0d pulses required 1", ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        int at, r, o0;
        div = 12'd2;
        restart_pulse(r);
        o0 = ovr_cnt;
        for (int j = 0; j < 4; j++) begin
            next_sample(1'b0, v, at);
            checks++; if (v !== 8'(j)) begin errors++; $display("FAIL b2b_val%0d: got %0d required %0d", j, v, j); end
            checks++; if (at - r != 5 + 3*j) begin errors++; $display("FAIL b2b_time%0d: got %0d required %0d", j, at - r, 5 + 3*j); end
        end
        @(negedge clk);
        checks++; if (ovr_cnt - o0 != 0) begin errors++; $display("FAIL b2b_overrun: got %0d pulses required 0", ovr_cnt - o0); end
    endtask

    task automatic test_restart;
        logic [7:0] v;
        int at, r, o0;
        div = 12'd3;
        next_sample(1'b0, v, at);
        next_sample(1'b0, v, at);
        @(negedge clk);
        o0 = ovr_cnt;
        restart_pulse(r);
        next_sample(1'b0, v, at);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL restart_val: got %0d required 0", v); end
        checks++; if (at - r != 6) begin errors++; $display("FAIL restart_time: got %0d required 6", at - r); end
        checks++; if (ovr_cnt - o0 != 0) begin errors++; $display("FAIL restart_overrun: got %0d pulses required 0", ovr_cnt - o0); end
    endtask

    task automatic test_enable;
        logic [7:0] v0, v;
        int k, at, seen;
        next_sample(1'b0, v0, k);
        en = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.pcm_vld === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL en_frozen: got %0d valid cycles required 0", seen); end
        en = 1'b1;
        next_sample(1'b0, v, at);
        checks++; if (v !== v0 + 8'd1) begin errors++; $display("FAIL en_resume_val: got %0d required %0d", v, v0 + 8'd1); end
        checks++; if (at - k != 54) begin errors++; $display("FAIL en_resume_time: got %0d required 54", at - k); end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        int at, r;
        logic [7:0] w [0:257];
        int idx [0:5] = '{0, 1, 17, 255, 256, 257};
        logic [7:0] exp_w [0:5] = '{8'd0, 8'd1, 8'd34, 8'd240, 8'd0, 8'd1};
        div = 12'd1;
        a = 4'd1; b = 4'd4; c = 4'd15; d = 4'd0; mode = 4'b1010;
        restart_pulse(r);
        for (int j = 0; j < 258; j++) begin next_sample(1'b1, v, at); w[j] = v; end
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (w[idx[n]] !== exp_w[n]) begin
                errors++; $display("FAIL wrap_t%0d: got %0d required %0d", idx[n], w[idx[n]], exp_w[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mixing();
        test_formulas();
        test_backpressure();
        test_back_to_back();
        test_restart();
        test_enable();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bytebeat_engine.md
# bytebeat_engine

Parametrised multi-channel bytebeat sample generator: a prescaled time counter `t` drives a shared, time-multiplexed formula datapath that evaluates `CHANNELS` voices, each with its own formula mode, and averages them into one PCM sample. The sample is presented on a valid/ready stream. It sits between the chip-level pin wrapper and the PCM/PWM output stage. It supersedes the fixed single-formula, free-running generator with a programmable sample rate, four selectable formulas, voice mixing, restart and overrun reporting.

## Interface
- `PCM_W`, 8: output sample width; must satisfy 1 ≤ `PCM_W` ≤ `T_W`.
- `T_W`, 16: width of the time counter `t` and of all formula arithmetic.
- `DIV_W`, 12: width of the prescaler divisor.
- `CHANNELS`, 2: voice count; power of two, 1..8.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable. Low freezes the prescaler and `t`. An in-flight sample still completes.
- `restart` in 1: synchronous one-cycle pulse. Clears `t` and the prescaler, and aborts any in-flight sample.
- `div` in `DIV_W`: a sample tick occurs every `div+1` cycles.
- `a`, `b`, `c`, `d` in 4 each: formula parameters, shared by all voices.
- `mode` in 2*`CHANNELS`: voice k uses `mode[2k+1:2k]`.
- `pcm_rdy` in 1: downstream ready.
- `pcm` out `PCM_W`: mixed sample.
- `pcm_vld` out 1: sample valid.
- `overrun` out 1: one-cycle pulse when a tick is dropped.

## Operation
- Prescaler `cnt` (`DIV_W` bits):
  - While `en`, `cnt` increments each cycle.
  - A tick fires when `cnt >= div`, and `cnt` then returns to 0. The `>=` comparison covers `div` being lowered mid-count.
  - `div`=0 produces a tick every cycle.
- On every tick, `t` increments, wrapping mod 2^`T_W`, whether or not the sample is accepted.
- State machine:
  - **IDLE**: on an accepted tick, latch `t_lat` = the pre-increment `t`, clear the accumulator and voice index, and go to COMPUTE.
  - **COMPUTE**: takes `CHANNELS` cycles, one voice per cycle (k = 0..`CHANNELS`-1). Each cycle adds the voice result to the accumulator. After the last voice, go to PRESENT.
  - **PRESENT**: `pcm_vld`=1. On `pcm_vld & pcm_rdy`, the transfer completes. If a tick occurs in that same cycle, it is accepted and the next state is COMPUTE; otherwise the next state is IDLE.
- Tick acceptance:
  - A tick is accepted only in IDLE, or in PRESENT with `pcm_rdy`=1.
  - A tick in any other state is dropped: `overrun` pulses in the next cycle, `t` still increments, and the held sample is untouched.
- Voice formulas use `t = t_lat`. All operations are mod 2^`T_W`; shifts are logical with a 4-bit amount; the voice result is the low `PCM_W` bits.
  - M0: `((t*a) & (t>>b)) | ((t*c) & (t>>d))`
  - M1: `(t*a) ^ (t>>b) ^ ((t*c)>>d)`
  - M2: `(t*(a + ((t>>b) & c))) >> d`
  - M3: `((t*a) + ((t>>b) & (t>>c))) >> d`
- Mixing:
  - The accumulator is `PCM_W`+log2(`CHANNELS`) bits and cannot overflow.
  - `pcm` = accumulator >> log2(`CHANNELS`), i.e. a truncating average.
- `a`, `b`, `c`, `d` and `mode` are sampled in the COMPUTE cycle of each voice. Changing them mid-sample is legal but may mix settings within that sample.
- `restart` has priority over everything:
  - Next cycle: `t`=0, `cnt`=0, state IDLE, `pcm_vld`=0. No `overrun` pulse is generated.
  - A tick in the same cycle as `restart` is discarded.
- `en` low: no ticks are generated. COMPUTE and PRESENT proceed normally.

## Timing
- Reset values: `pcm`=0, `pcm_vld`=0, `overrun`=0, `t`=0, `cnt`=0, state IDLE.
- After reset with `en`=1, the first tick fires at the cycle where `cnt` reaches `div`, i.e. the (`div`+1)th rising edge. That sample uses `t`=0.
- Latency: a tick accepted at cycle n gives `pcm_vld`=1 from cycle n+`CHANNELS`+1.
- Handshake:
  - `pcm` is stable while `pcm_vld & !pcm_rdy`.
  - `pcm_vld` never drops without a transfer, except on `restart` or reset.
- Sustained throughput is one sample per `CHANNELS`+1 cycles. With `div` < `CHANNELS`, ticks are dropped periodically with `overrun` pulses; this is legal.
- Registered outputs, no combinational paths from inputs to outputs.

## Test plan
- **Reset and first sample**: `CHANNELS`=2, `div`=3, `a`=1, `b`=`c`=`d`=0, both voices M0, `pcm_rdy`=1 → all outputs 0 during reset; ticks at edges 4, 8, 12; samples 0, 1, 2; `pcm_vld` 3 cycles after each tick.
- **Mixing**: `t_lat`=5 with `a`=1, `b`=`c`=`d`=0, voice 0 = M0 (result 5) and voice 1 = M1 (result 0) → `pcm`=2. Both voices M0 → `pcm`=5.
- **Backpressure**: hold `pcm_rdy`=0 across a tick → `pcm` stays stable, one `overrun` pulse, `t` advances. After release, the next sample uses `t` one step higher than a gapless run would.
- **Back-to-back**: `div`=2, `CHANNELS`=2, `pcm_rdy`=1 → a tick coinciding with the transfer cycle is accepted; no `overrun`; a continuous sample stream.
- **Restart**: pulse `restart` during COMPUTE → `pcm_vld` stays 0, the next sample uses `t`=0, the first tick comes `div`+1 cycles after restart, and no `overrun`.
- **Enable and wrap**: with `en`=0 for 50 cycles → no ticks and `t` frozen. Also, `T_W`=8 run for 256 ticks → `t` wraps 255 → 0 and sample values repeat.
